// File: rtl/store_buf_pkg.sv
// Shared types and constants for the write-posting store buffer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: default geometry, the word-address slice (the low two byte-offset
// bits are ignored when comparing addresses) and the buffered entry layout.
package store_buf_pkg;

    localparam int SB_DEPTH    = 4;
    localparam int SB_ADDR_W   = 32;
    localparam int SB_DATA_W   = 32;

    // Byte-offset bits dropped when two addresses are compared as words.
    localparam int SB_WORD_LSB = 2;

    // One buffered store, at the default widths.
    typedef struct packed {
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buf_match.sv
// Youngest-match finder over the valid window [head, head+count) of the store FIFO.
// Latency: purely combinational, 0 cycles.
// Backpressure: none; evaluated every cycle.
//
// Ports:
//   ent_word  word address (addr[ADDR_W-1:2]) of every FIFO slot
//   head      index of the oldest valid entry
//   count     number of valid entries
//   ld_word   word address of the current load
//   hit       some valid entry matches ld_word
//   hit_idx   slot index of the youngest matching entry (0 when no hit)
module store_buf_match
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int WORD_W = SB_ADDR_W - SB_WORD_LSB,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic [WORD_W-1:0] ent_word [DEPTH],
    input  logic [PTR_W-1:0]  head,
    input  logic [CNT_W-1:0]  count,
    input  logic [WORD_W-1:0] ld_word,
    output logic              hit,
    output logic [PTR_W-1:0]  hit_idx
);

    // Walk the window oldest-to-youngest; a later match overwrites an earlier
    // one, so the result ends up pointing at the entry closest to tail.
    // DEPTH is a power of two, so the PTR_W-bit add wraps the index for free.
    always_comb begin
        logic [PTR_W-1:0] idx;
        hit     = 1'b0;
        hit_idx = '0;
        idx     = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && (ent_word[idx] == ld_word)) begin
                hit     = 1'b1;
                hit_idx = idx;
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// Write-posting store buffer between the MEM stage and the single data-memory port.
// Latency: loads 0 cycles (combinational); a store is written at the earliest in the cycle after it is accepted.
// Backpressure: st_ready = (count < DEPTH) from registered state; loads always win the port, so drains may starve.
//
// Ports:
//   clk, rst_n                 clock; synchronous active-low reset
//   st_valid/st_addr/st_data   store from the pipeline, taken when st_ready is high
//   st_ready                   buffer has a free slot
//   ld_req/ld_addr             load from the pipeline
//   ld_data                    load result in the same cycle (0 when no load)
//   ld_stall                   load must be held this cycle
//   empty                      no buffered stores (fence/syscall logic)
//   mem_*                      single shared data-memory port, combinational read
//
// Build option STORE_BUF_FWD_EN:
//   defined   - a load hitting a buffered store gets the youngest store's data; ld_stall is 0.
//   undefined - a load hitting a buffered store stalls while the buffer drains;
//               the load completes once no entry matches, reading memory.
module store_buffer
    import store_buf_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              st_valid,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_data,
    output logic              st_ready,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_stall,
    output logic              empty,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int WORD_W = ADDR_W - SB_WORD_LSB;

    // ------------------------------------------------------------------
    // FIFO storage and pointers
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] ent_addr [DEPTH];
    logic [DATA_W-1:0] ent_data [DEPTH];
    logic [WORD_W-1:0] ent_word [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    logic push;
    logic drain;
    logic load_own;
    logic hit;
    logic [PTR_W-1:0]  hit_idx;
    logic [DATA_W-1:0] ld_data_sel;

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        assign ent_word[g] = ent_addr[g][ADDR_W-1:SB_WORD_LSB];
    end

    // Only registered entries are searched, so a store pushed this cycle is
    // invisible to a load in the same cycle.
    store_buf_match #(
        .DEPTH  (DEPTH),
        .WORD_W (WORD_W)
    ) u_match (
        .ent_word (ent_word),
        .head     (head),
        .count    (count),
        .ld_word  (ld_addr[ADDR_W-1:SB_WORD_LSB]),
        .hit      (hit),
        .hit_idx  (hit_idx)
    );

    // ------------------------------------------------------------------
    // Forwarding or stall-on-hit
    // ------------------------------------------------------------------
`ifdef STORE_BUF_FWD_EN
    assign ld_stall    = 1'b0;
    assign ld_data_sel = hit ? ent_data[hit_idx] : mem_read_data;
`else
    // Stalled loads give the port to the drain, which pops in FIFO order
    // until the last matching entry has reached memory.
    logic unused_hit_idx;
    assign unused_hit_idx = ^hit_idx;
    assign ld_stall       = rst_n && ld_req && hit;
    assign ld_data_sel    = mem_read_data;
`endif

    // ------------------------------------------------------------------
    // Handshakes and port arbitration
    // ------------------------------------------------------------------
    // st_ready looks only at registered count: a full buffer refuses a store
    // even in a cycle where it also drains.
    assign st_ready = rst_n && (count < CNT_W'(DEPTH));
    assign empty    = !rst_n || (count == '0);
    assign ld_data  = (rst_n && ld_req) ? ld_data_sel : '0;

    assign push     = st_valid && st_ready;
    assign load_own = rst_n && ld_req && !ld_stall;
    assign drain    = rst_n && !load_own && (count != '0);

    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read        = 1'b0;
        if (load_own) begin
            mem_read        = 1'b1;
            mem_access_addr = ld_addr;
        end else if (drain) begin
            mem_write_en    = 1'b1;
            mem_access_addr = ent_addr[head];
            mem_write_data  = ent_data[head];
        end
    end

    // ------------------------------------------------------------------
    // State update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (drain) begin
                head <= head + PTR_W'(1);
            end
            case ({push, drain})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Slot contents need no reset: count alone decides which slots are live,
    // and push is held low while rst_n is low.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
        end
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Write-posting store buffer between the MEM stage of the MIPS pipeline and `data_memory`. It accepts full-word stores from the pipeline into a small FIFO. It drains them into the single shared data-memory port whenever no load needs that port. Loads go straight through to memory, and the youngest buffered store to the same word is forwarded, so the pipeline never waits on a store write.

## Interface
- `DEPTH`, 4: buffer entries; power of two, minimum 2.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `st_valid`  in  1  pipeline presents a store this cycle.
- `st_addr`  in  ADDR_W  store byte address.
- `st_data`  in  DATA_W  store data, full word.
- `st_ready`  out  1  buffer can accept a store; equals `count < DEPTH`.
- `ld_req`  in  1  pipeline load this cycle.
- `ld_addr`  in  ADDR_W  load byte address.
- `ld_data`  out  DATA_W  load result, valid in the same cycle as `ld_req`.
- `ld_stall`  out  1  load cannot complete this cycle; the pipeline holds the load.
- `empty`  out  1  no buffered stores; used by the fence/syscall logic.
- `mem_access_addr`  out  ADDR_W  to data memory.
- `mem_write_data`  out  DATA_W  to data memory.
- `mem_write_en`  out  1  to data memory.
- `mem_read`  out  1  to data memory.
- `mem_read_data`  in  DATA_W  from data memory; combinational read.

## Operation
- The FIFO holds `DEPTH` entries of {addr, data}, with `head` and `tail` pointers modulo `DEPTH` and `count` of width clog2(DEPTH+1).
- Push: `st_valid && st_ready` writes {`st_addr`, `st_data`} at `tail`, then `tail+1` and `count+1`.
- If `st_valid` is high while `st_ready` is low, the store is not taken. The pipeline must hold the store.
- Port arbitration, decided combinationally each cycle:
  - A load owns the port when `ld_req` is high and `ld_stall` is low. Outputs: `mem_read=1`, `mem_access_addr=ld_addr`, `mem_write_en=0`.
  - Otherwise, if `count>0`, the buffer drains. Outputs: `mem_write_en=1`, address and data taken from the `head` entry, `mem_read=0`. At the clock edge, `head+1` and `count-1`.
  - Otherwise the port is idle: all memory outputs are 0.
- Match rule: an entry matches a load when `entry.addr[ADDR_W-1:2] == ld_addr[ADDR_W-1:2]`, i.e. word granularity.
- Only valid entries between `head` and `tail` are compared. When several entries match, the youngest wins (the one closest to `tail`).
- `ld_data` is the youngest matching entry's data if there is a match, otherwise `mem_read_data`. It is 0 when `ld_req` is low.
- A store pushed in the same cycle as a load is not visible to that load. Forwarding sees registered entries only.
- A push and a drain in the same cycle leave `count` unchanged and move both pointers.
- `empty = (count==0)`.

## Timing
- Reset (`rst_n` low at an edge) sets `head`, `tail` and `count` to 0 and discards every buffered entry.
- While `rst_n` is low, outputs are forced to:
  - `st_ready=0`, `ld_stall=0`, `ld_data=0`, `empty=1`
  - `mem_write_en=0`, `mem_read=0`, `mem_access_addr=0`, `mem_write_data=0`
- Reset asserted mid-drain aborts the drain. No write is issued while reset is low.
- Store latency: a store accepted at edge N is drainable in cycle N+1 at the earliest. It is written at the edge that ends the first cycle with no owning load.
- Load latency is 0 cycles: combinational from `ld_addr` to `ld_data`.
- `st_ready` depends only on registered `count`. A store is never taken when the buffer is full, even if a drain happens in the same cycle.
- Pointer wrap: `DEPTH-1` wraps to 0.
- Continuous loads starve draining. A full buffer then backpressures stores through `st_ready`, which is intended.

## Configuration
- `STORE_BUF_FWD_EN` defined: forwarding as described; `ld_stall` is constant 0.
- `STORE_BUF_FWD_EN` undefined: no forwarding path. A load that matches any buffered entry raises `ld_stall=1`. The port goes to draining until no entry matches, and `ld_stall` drops in the cycle the last matching entry has been popped. In that mode `ld_data` always comes from `mem_read_data`.

## Structure
- Package `store_buf_pkg` holds:
  - the entry typedef {addr, data};
  - default `DEPTH`, `ADDR_W`, `DATA_W`;
  - the word-address slice constant (low 2 bits ignored).
- Sub-module `store_buf_match`: combinational youngest-match finder. Inputs are the entry array, `head`, `count` and `ld_addr`. Outputs are `hit` and `hit_idx`.

## Test plan
- Reset, then push A=0x10/D=0x11 with no loads: write at 0x10 with 0x11 next cycle, then `empty=1`.
- Push 4 stores with `ld_req` held high: `st_ready=0` after the 4th, no `mem_write_en`. Release `ld_req`: 4 writes in FIFO order, with the pointer wrapping on the next pushes.
- Push 0x20=0xAA then 0x20=0xBB, load 0x22 while `ld_req` blocks drain: `ld_data=0xBB` (FWD_EN) or `ld_stall=1` for the drain cycles, then memory value 0xBB (no FWD_EN).
- Load 0x40 with no match and memory holding 0x55: `mem_read=1`, `ld_data=0x55`, drain suppressed that cycle.
- Push and drain in the same cycle at `count=2`: `count` stays 2, `head` and `tail` both advance.
- Assert `rst_n=0` with 3 entries buffered: no writes, `empty=1`. After release, a load to a previously stored address returns `mem_read_data`.
